// File: rtl/simplebus_pkg.sv
// simplebus_pkg
// Shared constants and types for the simplebus two-master arbiter.
//   - FSM state encodings (ARB_IDLE, ARB_BUSY_IFU, ARB_BUSY_LSU)
//   - access size codes (SIZE_B, SIZE_H, SIZE_W)
//   - default abort timeout used when ARB_TIMEOUT_EN is defined
//   - latched request record and a helper that builds an IFU fetch request
package simplebus_pkg;

    localparam logic [1:0] ARB_IDLE     = 2'd0;
    localparam logic [1:0] ARB_BUSY_IFU = 2'd1;
    localparam logic [1:0] ARB_BUSY_LSU = 2'd2;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam int ARB_DEFAULT_TIMEOUT = 255;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } simplebus_req_t;

    // Instruction fetches are always full-word reads with no write payload.
    function automatic simplebus_req_t ifuRequest(input logic [31:0] addr);
        simplebus_req_t req;
        req.addr  = addr;
        req.size  = SIZE_W;
        req.wen   = 1'b0;
        req.wdata = 32'h0;
        req.wmask = 4'h0;
        return req;
    endfunction

endpackage

// File: rtl/simplebus_timeout_ctr.sv
// simplebus_timeout_ctr
// Counts BUSY cycles that pass without a memory response and flags the
// cycle in which the LIMIT-th such cycle is in progress.
// Only instantiated when ARB_TIMEOUT_EN is defined.
// Ports:
//   clock     in  rising-edge clock
//   reset     in  synchronous, active-low reset
//   i_clear   in  hold the count at zero (arbiter idle)
//   i_enable  in  count this cycle (busy and no response)
//   o_hit     out current busy cycle is the LIMIT-th without a response
module simplebus_timeout_ctr
    import simplebus_pkg::*;
#(
    parameter int LIMIT = ARB_DEFAULT_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_hit
);

    logic [15:0] r_count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= 16'd0;
        end else if (i_clear) begin
            r_count <= 16'd0;
        end else if (i_enable) begin
            r_count <= r_count + 16'd1;
        end
    end

    // r_count holds the number of completed silent cycles, so the current
    // cycle is the LIMIT-th one when LIMIT-1 have already elapsed.
    assign o_hit = (r_count == 16'(LIMIT - 1));

endmodule

// File: rtl/simplebus_arbiter.sv
// simplebus_arbiter
// Two-master (IFU, LSU), one-slave arbiter for the core memory bus.
// Grants one requester at a time, latches its request fields, and passes the
// memory response straight through to the granted requester only. Ties in
// IDLE go to the requester that was not granted last (LSU wins the first).
// Configuration macro: ARB_TIMEOUT_EN -- when defined, a BUSY phase lasting
// TIMEOUT_CYCLES cycles without a response is aborted with bus_err.
// Ports:
//   clock, reset                 clock and synchronous active-low reset
//   ifu_reqValid, ifu_addr       IFU fetch request
//   ifu_respValid, ifu_rdata     IFU response
//   lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask  LSU request
//   lsu_respValid, lsu_rdata     LSU response
//   mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask  memory request
//   mem_respValid, mem_rdata     memory response
//   bus_err                      aborted transaction indicator
module simplebus_arbiter
    import simplebus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = ARB_DEFAULT_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_reqValid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_respValid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_reqValid,
    input  logic [31:0] lsu_addr,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_respValid,
    output logic [31:0] lsu_rdata,
    output logic        mem_reqValid,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_size,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_respValid,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    logic [1:0]     r_state;
    logic           r_lastLsu;
    simplebus_req_t r_req;

    logic           w_busy;
    logic           w_grantLsu;
    logic           w_grantIfu;
    logic           w_abort;
    logic           w_done;
    logic           w_respValid;
    logic [31:0]    w_respData;
    simplebus_req_t w_lsuReq;

    // Any non-busy encoding (including the unused one) behaves as IDLE.
    assign w_busy = (r_state == ARB_BUSY_IFU) || (r_state == ARB_BUSY_LSU);

    // LSU wins unless IFU also wants the bus and LSU had the previous grant.
    assign w_grantLsu = !w_busy && lsu_reqValid && (!ifu_reqValid || !r_lastLsu);
    assign w_grantIfu = !w_busy && ifu_reqValid && !w_grantLsu;

    assign w_done = w_busy && (mem_respValid || w_abort);

    assign w_lsuReq = '{addr:  lsu_addr,
                        size:  lsu_size,
                        wen:   lsu_wen,
                        wdata: lsu_wdata,
                        wmask: lsu_wmask};

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= ARB_IDLE;
            r_lastLsu <= 1'b0;
            r_req     <= '0;
        end else if (w_grantLsu) begin
            r_state   <= ARB_BUSY_LSU;
            r_lastLsu <= 1'b1;
            r_req     <= w_lsuReq;
        end else if (w_grantIfu) begin
            r_state   <= ARB_BUSY_IFU;
            r_lastLsu <= 1'b0;
            r_req     <= ifuRequest(ifu_addr);
        end else if (w_done || !w_busy) begin
            r_state   <= ARB_IDLE;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic w_timeoutHit;

    simplebus_timeout_ctr #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeoutCtr (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (!w_busy),
        .i_enable (w_busy && !mem_respValid),
        .o_hit    (w_timeoutHit)
    );

    assign w_abort = w_busy && w_timeoutHit;
`else
    logic [15:0] w_unusedTimeout;

    assign w_unusedTimeout = 16'(TIMEOUT_CYCLES);
    assign w_abort         = 1'b0;
`endif

    assign mem_reqValid = w_busy;
    assign mem_addr     = r_req.addr;
    assign mem_size     = r_req.size;
    assign mem_wen      = r_req.wen;
    assign mem_wdata    = r_req.wdata;
    assign mem_wmask    = r_req.wmask;

    // A real response in the abort cycle takes precedence, so data is only
    // forwarded when the memory actually answered.
    assign w_respValid = w_busy && (mem_respValid || w_abort);
    assign w_respData  = (w_busy && mem_respValid) ? mem_rdata : 32'h0;

    assign ifu_respValid = (r_state == ARB_BUSY_IFU) && w_respValid;
    assign ifu_rdata     = (r_state == ARB_BUSY_IFU) ? w_respData : 32'h0;
    assign lsu_respValid = (r_state == ARB_BUSY_LSU) && w_respValid;
    assign lsu_rdata     = (r_state == ARB_BUSY_LSU) ? w_respData : 32'h0;

    assign bus_err = w_abort && !mem_respValid;

endmodule

// File: tb/tb_simplebus_arbiter.sv
// tb_simplebus_arbiter
// Self-checking bench for simplebus_arbiter. Directed request vectors come
// from a table; expected responses go into a scoreboard queue when the memory
// answer is driven and are popped by a monitor whenever a response strobe (or
// bus_err) is observed. Hand-written sequences cover ties, isolation, reset
// mid-transaction and, when ARB_TIMEOUT_EN is defined, the abort path.
module tb_simplebus_arbiter;

    logic        clock;
    logic        reset;
    logic        ifu_reqValid;
    logic [31:0] ifu_addr;
    logic        ifu_respValid;
    logic [31:0] ifu_rdata;
    logic        lsu_reqValid;
    logic [31:0] lsu_addr;
    logic [1:0]  lsu_size;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;
    logic        mem_reqValid;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_respValid;
    logic [31:0] mem_rdata;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        isLsu;
        logic [31:0] rdata;
        logic        busErr;
    } sbEntry_t;

    sbEntry_t sbQueue[$];

    typedef struct {
        logic        isLsu;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          delay;
        logic [31:0] memData;
        logic [1:0]  expSize;
        logic        expWen;
        logic [31:0] expWdata;
        logic [3:0]  expWmask;
    } vec_t;

    vec_t vecs[5];

    simplebus_arbiter #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ifu_reqValid  (ifu_reqValid),
        .ifu_addr      (ifu_addr),
        .ifu_respValid (ifu_respValid),
        .ifu_rdata     (ifu_rdata),
        .lsu_reqValid  (lsu_reqValid),
        .lsu_addr      (lsu_addr),
        .lsu_size      (lsu_size),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_respValid (lsu_respValid),
        .lsu_rdata     (lsu_rdata),
        .mem_reqValid  (mem_reqValid),
        .mem_addr      (mem_addr),
        .mem_size      (mem_size),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_respValid (mem_respValid),
        .mem_rdata     (mem_rdata),
        .bus_err       (bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkMem(input logic [31:0] addr, input logic [1:0] size,
                            input logic wen, input logic [31:0] wdata,
                            input logic [3:0] wmask);
        checkOutput("memReqValid", 32'(mem_reqValid), 32'd1);
        checkOutput("memAddr", mem_addr, addr);
        checkOutput("memSize", 32'(mem_size), 32'(size));
        checkOutput("memWen", 32'(mem_wen), 32'(wen));
        checkOutput("memWdata", mem_wdata, wdata);
        checkOutput("memWmask", 32'(mem_wmask), 32'(wmask));
    endtask

    // Response monitor: every strobe must match the oldest expected response.
    always @(negedge clock) begin
        if (ifu_respValid || lsu_respValid || bus_err) begin
            if (sbQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedResp: ifu=%0b lsu=%0b busErr=%0b, expected no response",
                         ifu_respValid, lsu_respValid, bus_err);
            end else begin
                sbEntry_t exp;
                exp = sbQueue.pop_front();
                checkOutput("respLsu", 32'(lsu_respValid), 32'(exp.isLsu));
                checkOutput("respIfu", 32'(ifu_respValid), 32'(!exp.isLsu));
                checkOutput("respLsuData", lsu_rdata, exp.isLsu ? exp.rdata : 32'h0);
                checkOutput("respIfuData", ifu_rdata, exp.isLsu ? 32'h0 : exp.rdata);
                checkOutput("respBusErr", 32'(bus_err), 32'(exp.busErr));
            end
        end
    end

    // Called just after the edge that starts an IDLE cycle with the request
    // already driven; returns just after the edge that starts the next IDLE.
    task automatic applyStimulus(input logic expLsu, input logic [31:0] expAddr,
                                 input logic [1:0] expSize, input logic expWen,
                                 input logic [31:0] expWdata, input logic [3:0] expWmask,
                                 input int delay, input logic [31:0] memData);
        @(negedge clock);
        checkOutput("idleReqValid", 32'(mem_reqValid), 32'd0);
        @(posedge clock); #1;
        for (int c = 0; c < delay; c++) begin
            @(negedge clock);
            checkMem(expAddr, expSize, expWen, expWdata, expWmask);
            @(posedge clock); #1;
        end
        mem_respValid = 1'b1;
        mem_rdata     = memData;
        sbQueue.push_back('{isLsu: expLsu, rdata: memData, busErr: 1'b0});
        @(negedge clock);
        checkMem(expAddr, expSize, expWen, expWdata, expWmask);
        @(posedge clock); #1;
        mem_respValid = 1'b0;
        mem_rdata     = 32'h5555_5555;
    endtask

    initial begin
        reset         = 1'b0;
        ifu_reqValid  = 1'b0;
        ifu_addr      = 32'h0;
        lsu_reqValid  = 1'b0;
        lsu_addr      = 32'h0;
        lsu_size      = 2'd0;
        lsu_wen       = 1'b0;
        lsu_wdata     = 32'h0;
        lsu_wmask     = 4'h0;
        mem_respValid = 1'b0;
        mem_rdata     = 32'h5555_5555;

        vecs[0] = '{isLsu: 1'b0, addr: 32'h8000_0000, size: 2'd1, wen: 1'b1,
                    wdata: 32'h0000_1234, wmask: 4'hF, delay: 0, memData: 32'h0010_0073,
                    expSize: 2'd2, expWen: 1'b0, expWdata: 32'h0, expWmask: 4'h0};
        vecs[1] = '{isLsu: 1'b1, addr: 32'h8000_1004, size: 2'd0, wen: 1'b1,
                    wdata: 32'h0000_00A5, wmask: 4'h1, delay: 2, memData: 32'h0000_0000,
                    expSize: 2'd0, expWen: 1'b1, expWdata: 32'h0000_00A5, expWmask: 4'h1};
        vecs[2] = '{isLsu: 1'b1, addr: 32'h8000_2000, size: 2'd2, wen: 1'b0,
                    wdata: 32'h0, wmask: 4'h0, delay: 1, memData: 32'hCAFE_BABE,
                    expSize: 2'd2, expWen: 1'b0, expWdata: 32'h0, expWmask: 4'h0};
        vecs[3] = '{isLsu: 1'b0, addr: 32'h8000_0004, size: 2'd0, wen: 1'b1,
                    wdata: 32'hFFFF_FFFF, wmask: 4'h3, delay: 2, memData: 32'h0000_0013,
                    expSize: 2'd2, expWen: 1'b0, expWdata: 32'h0, expWmask: 4'h0};
        vecs[4] = '{isLsu: 1'b1, addr: 32'h8000_3002, size: 2'd1, wen: 1'b0,
                    wdata: 32'h0, wmask: 4'h0, delay: 0, memData: 32'h0000_BEEF,
                    expSize: 2'd1, expWen: 1'b0, expWdata: 32'h0, expWmask: 4'h0};

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("rstReqValid", 32'(mem_reqValid), 32'd0);
        checkOutput("rstIfuResp", 32'(ifu_respValid), 32'd0);
        checkOutput("rstLsuResp", 32'(lsu_respValid), 32'd0);
        checkOutput("rstIfuData", ifu_rdata, 32'h0);
        checkOutput("rstLsuData", lsu_rdata, 32'h0);
        checkOutput("rstBusErr", 32'(bus_err), 32'd0);
        checkOutput("rstMemAddr", mem_addr, 32'h0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Tie from reset: LSU, then IFU, then LSU again, both re-requesting
        $display("[TB] tie arbitration");
        ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0100;
        lsu_reqValid = 1'b1; lsu_addr = 32'h8001_0000; lsu_size = 2'd2;
        lsu_wen = 1'b1; lsu_wdata = 32'h11; lsu_wmask = 4'hF;
        applyStimulus(1'b1, 32'h8001_0000, 2'd2, 1'b1, 32'h11, 4'hF, 0, 32'h0000_0001);
        lsu_addr = 32'h8001_0004; lsu_wdata = 32'h22;
        applyStimulus(1'b0, 32'h8000_0100, 2'd2, 1'b0, 32'h0, 4'h0, 0, 32'h0000_0013);
        ifu_addr = 32'h8000_0104;
        applyStimulus(1'b1, 32'h8001_0004, 2'd2, 1'b1, 32'h22, 4'hF, 1, 32'h0000_0002);
        lsu_reqValid = 1'b0;
        applyStimulus(1'b0, 32'h8000_0104, 2'd2, 1'b0, 32'h0, 4'h0, 0, 32'h0000_0093);
        ifu_reqValid = 1'b0;

        // Table-driven single-requester transactions
        $display("[TB] vector table");
        for (int i = 0; i < 5; i++) begin
            ifu_reqValid = !vecs[i].isLsu;
            lsu_reqValid = vecs[i].isLsu;
            ifu_addr     = vecs[i].isLsu ? 32'h0BAD_0000 : vecs[i].addr;
            lsu_addr     = vecs[i].isLsu ? vecs[i].addr : 32'h0BAD_1000;
            lsu_size     = vecs[i].size;
            lsu_wen      = vecs[i].wen;
            lsu_wdata    = vecs[i].wdata;
            lsu_wmask    = vecs[i].wmask;
            applyStimulus(vecs[i].isLsu, vecs[i].addr, vecs[i].expSize, vecs[i].expWen,
                          vecs[i].expWdata, vecs[i].expWmask, vecs[i].delay, vecs[i].memData);
            ifu_reqValid = 1'b0;
            lsu_reqValid = 1'b0;
        end

        // Response isolation with IFU fields changing during BUSY_LSU
        $display("[TB] response isolation");
        lsu_reqValid = 1'b1; lsu_addr = 32'h8000_4000; lsu_size = 2'd2;
        lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
        @(negedge clock);
        checkOutput("isoIdleReqValid", 32'(mem_reqValid), 32'd0);
        @(posedge clock); #1;
        ifu_addr = 32'hDEAD_0000;
        @(negedge clock);
        checkOutput("isoAddr1", mem_addr, 32'h8000_4000);
        @(posedge clock); #1;
        ifu_addr = 32'hDEAD_0004; ifu_reqValid = 1'b1;
        @(negedge clock);
        checkOutput("isoAddr2", mem_addr, 32'h8000_4000);
        checkOutput("isoIfuResp", 32'(ifu_respValid), 32'd0);
        @(posedge clock); #1;
        mem_respValid = 1'b1; mem_rdata = 32'h0000_7777;
        sbQueue.push_back('{isLsu: 1'b1, rdata: 32'h0000_7777, busErr: 1'b0});
        @(negedge clock);
        checkOutput("isoAddr3", mem_addr, 32'h8000_4000);
        @(posedge clock); #1;
        mem_respValid = 1'b0; mem_rdata = 32'h5555_5555; lsu_reqValid = 1'b0;
        applyStimulus(1'b0, 32'hDEAD_0004, 2'd2, 1'b0, 32'h0, 4'h0, 0, 32'h0000_0073);
        ifu_reqValid = 1'b0;

        // Reset asserted mid-BUSY, then a stray response
        $display("[TB] reset mid-transaction");
        lsu_reqValid = 1'b1; lsu_addr = 32'h8000_6000;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("midRstBusy", 32'(mem_reqValid), 32'd1);
        @(posedge clock); #1;
        reset = 1'b1; lsu_reqValid = 1'b0;
        @(negedge clock);
        checkOutput("midRstReqValid", 32'(mem_reqValid), 32'd0);
        checkOutput("midRstAddr", mem_addr, 32'h0);
        @(posedge clock); #1;
        mem_respValid = 1'b1; mem_rdata = 32'h0000_4444;
        @(negedge clock);
        checkOutput("strayLsuResp", 32'(lsu_respValid), 32'd0);
        checkOutput("strayReqValid", 32'(mem_reqValid), 32'd0);
        @(posedge clock); #1;
        mem_respValid = 1'b0; mem_rdata = 32'h5555_5555;
        @(negedge clock);
        checkOutput("strayStillIdle", 32'(mem_reqValid), 32'd0);
        @(posedge clock); #1;

`ifdef ARB_TIMEOUT_EN
        $display("[TB] timeout abort");
        lsu_reqValid = 1'b1; lsu_addr = 32'h8000_5000; lsu_size = 2'd2;
        lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
        @(negedge clock);
        checkOutput("toIdleReqValid", 32'(mem_reqValid), 32'd0);
        @(posedge clock); #1;
        for (int c = 1; c < 4; c++) begin
            @(negedge clock);
            checkOutput("toWaitReqValid", 32'(mem_reqValid), 32'd1);
            checkOutput("toWaitBusErr", 32'(bus_err), 32'd0);
            @(posedge clock); #1;
        end
        sbQueue.push_back('{isLsu: 1'b1, rdata: 32'h0, busErr: 1'b1});
        @(negedge clock);
        checkOutput("toAbortReqValid", 32'(mem_reqValid), 32'd1);
        @(posedge clock); #1;
        lsu_reqValid = 1'b0;
        @(negedge clock);
        checkOutput("toAfterReqValid", 32'(mem_reqValid), 32'd0);
        @(posedge clock); #1;
        mem_respValid = 1'b1; mem_rdata = 32'h0000_1234;
        @(negedge clock);
        checkOutput("toLateIgnored", 32'(lsu_respValid), 32'd0);
        @(posedge clock); #1;
        mem_respValid = 1'b0; mem_rdata = 32'h5555_5555;
        // Response landing exactly in the abort cycle wins over the abort
        lsu_reqValid = 1'b1; lsu_addr = 32'h8000_5004;
        applyStimulus(1'b1, 32'h8000_5004, 2'd2, 1'b0, 32'h0, 4'h0, 3, 32'h0000_ABCD);
        lsu_reqValid = 1'b0;
`else
        $display("[TB] long wait without timeout");
        lsu_reqValid = 1'b1; lsu_addr = 32'h8000_5000; lsu_size = 2'd2;
        lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
        applyStimulus(1'b1, 32'h8000_5000, 2'd2, 1'b0, 32'h0, 4'h0, 10, 32'h0000_ABCD);
        lsu_reqValid = 1'b0;
`endif

        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("sbEmpty", 32'(sbQueue.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
